// File: rtl/sram_bus_bank.sv
// AT91 static-memory bus slave with a banked, byte-lane-writable RAM, a user-side port
// and per-bank doorbells raised when the CPU writes a bank's top word.
module sram_bus_bank #(
    parameter int DW    = 16,
    parameter int AW    = 10,
    parameter int NBANK = 2,
    parameter int SYNC  = 2
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DW-1:0]     sram_data,
    input  logic [AW-1:0]     addr,
    input  logic [DW/8-1:0]   nbe,
    input  logic              ncs,
    input  logic              nwe,
    input  logic              noe,
    input  logic [AW-1:0]     usr_addr,
    input  logic              usr_we,
    input  logic [DW-1:0]     usr_wdata,
    output logic [DW-1:0]     usr_rdata,
    output logic [NBANK-1:0]  doorbell,
    input  logic [NBANK-1:0]  db_clr,
    output logic              busy
);

    localparam int NB    = DW / 8;
    localparam int BW    = $clog2(NBANK);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_FETCH,
        READ_DRIVE
    } state_t;

    // Synchroniser chains; every bus input is delayed by the same SYNC stages.
    logic [SYNC-1:0] ncs_sync_q, ncs_sync_d;
    logic [SYNC-1:0] nwe_sync_q, nwe_sync_d;
    logic [SYNC-1:0] noe_sync_q, noe_sync_d;
    logic [NB-1:0]   nbe_sync_q  [SYNC];
    logic [NB-1:0]   nbe_sync_d  [SYNC];
    logic [AW-1:0]   addr_sync_q [SYNC];
    logic [AW-1:0]   addr_sync_d [SYNC];
    logic [DW-1:0]   data_sync_q [SYNC];
    logic [DW-1:0]   data_sync_d [SYNC];

    logic            ncs_s, nwe_s, noe_s;
    logic [NB-1:0]   nbe_s;
    logic [AW-1:0]   addr_s;
    logic [DW-1:0]   data_s;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [NB-1:0]   wr_nbe_q, wr_nbe_d;
    logic [DW-1:0]   rd_q, rd_d;
    logic            rd_valid_q, rd_valid_d;
    logic [DW-1:0]   usr_rdata_q, usr_rdata_d;
    logic [NBANK-1:0] doorbell_q, doorbell_d;

    logic            commit_en;
    logic            usr_collide;
    logic [NBANK-1:0] db_set;
    logic            drive_en;

    logic [DW-1:0]   mem [DEPTH];

    always_comb begin
        ncs_sync_d     = {ncs_sync_q[SYNC-2:0], ncs};
        nwe_sync_d     = {nwe_sync_q[SYNC-2:0], nwe};
        noe_sync_d     = {noe_sync_q[SYNC-2:0], noe};
        nbe_sync_d[0]  = nbe;
        addr_sync_d[0] = addr;
        data_sync_d[0] = sram_data;
        for (int i = 1; i < SYNC; i++) begin
            nbe_sync_d[i]  = nbe_sync_q[i-1];
            addr_sync_d[i] = addr_sync_q[i-1];
            data_sync_d[i] = data_sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ncs_sync_q <= '1;
            nwe_sync_q <= '1;
            noe_sync_q <= '1;
            for (int i = 0; i < SYNC; i++) begin
                nbe_sync_q[i]  <= '1;
                addr_sync_q[i] <= '0;
                data_sync_q[i] <= '0;
            end
        end else begin
            ncs_sync_q <= ncs_sync_d;
            nwe_sync_q <= nwe_sync_d;
            noe_sync_q <= noe_sync_d;
            for (int i = 0; i < SYNC; i++) begin
                nbe_sync_q[i]  <= nbe_sync_d[i];
                addr_sync_q[i] <= addr_sync_d[i];
                data_sync_q[i] <= data_sync_d[i];
            end
        end
    end

    assign ncs_s  = ncs_sync_q[SYNC-1];
    assign nwe_s  = nwe_sync_q[SYNC-1];
    assign noe_s  = noe_sync_q[SYNC-1];
    assign nbe_s  = nbe_sync_q[SYNC-1];
    assign addr_s = addr_sync_q[SYNC-1];
    assign data_s = data_sync_q[SYNC-1];

    // Write wins over read when both strobes are low; a write commits the last held sample.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_nbe_d   = wr_nbe_q;
        rd_d       = rd_q;
        rd_valid_d = rd_valid_q;
        commit_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ncs_s && !nwe_s) begin
                    state_d   = WRITE;
                    wr_addr_d = addr_s;
                    wr_data_d = data_s;
                    wr_nbe_d  = nbe_s;
                end else if (!ncs_s && !noe_s) begin
                    state_d = READ_FETCH;
                end
            end
            WRITE: begin
                if (ncs_s || nwe_s) begin
                    commit_en = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wr_addr_d = addr_s;
                    wr_data_d = data_s;
                    wr_nbe_d  = nbe_s;
                end
            end
            READ_FETCH: begin
                rd_d       = mem[addr_s];
                rd_valid_d = 1'b1;
                state_d    = READ_DRIVE;
            end
            READ_DRIVE: begin
                if (noe_s || ncs_s) begin
                    rd_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    assign usr_collide = commit_en && (wr_addr_q == usr_addr);

    // The user read sees what the RAM will hold after this edge; the CPU wins a collision.
    always_comb begin
        usr_rdata_d = mem[usr_addr];
        if (usr_collide) begin
            for (int i = 0; i < NB; i++) begin
                if (!wr_nbe_q[i]) begin
                    usr_rdata_d[i*8 +: 8] = wr_data_q[i*8 +: 8];
                end
            end
        end else if (usr_we) begin
            usr_rdata_d = usr_wdata;
        end
    end

    always_comb begin
        db_set = '0;
        if (commit_en && (&wr_addr_q[AW-BW-1:0])) begin
            db_set[wr_addr_q[AW-1 -: BW]] = 1'b1;
        end
        doorbell_d = (doorbell_q & ~db_clr) | db_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_nbe_q    <= '1;
            rd_q        <= '0;
            rd_valid_q  <= 1'b0;
            usr_rdata_q <= '0;
            doorbell_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_nbe_q    <= wr_nbe_d;
            rd_q        <= rd_d;
            rd_valid_q  <= rd_valid_d;
            usr_rdata_q <= usr_rdata_d;
            doorbell_q  <= doorbell_d;
        end
    end

    // RAM contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk) begin
        if (commit_en) begin
            for (int i = 0; i < NB; i++) begin
                if (!wr_nbe_q[i]) begin
                    mem[wr_addr_q][i*8 +: 8] <= wr_data_q[i*8 +: 8];
                end
            end
        end
        if (usr_we && !usr_collide) begin
            mem[usr_addr] <= usr_wdata;
        end
    end

    // Bus release follows the raw pins so the CPU never sees a late driver.
    assign drive_en  = rd_valid_q & ~noe & ~ncs & nwe;
    assign sram_data = drive_en ? rd_q : 'z;

    assign usr_rdata = usr_rdata_q;
    assign doorbell  = doorbell_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_bus_bank.sv
// Self-checking bench for sram_bus_bank: directed vector table, hand-written corner
// sequences and randomized traffic against a word-array reference model.
module tb_sram_bus_bank;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int NBANK = 2;
    localparam int SYNC  = 2;
    localparam int NB    = DW / 8;
    localparam int BW    = $clog2(NBANK);
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] PULL = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    tri1  [DW-1:0]    sram_data;
    logic             tb_drive;
    logic [DW-1:0]    tb_wdata;
    logic [AW-1:0]    addr;
    logic [NB-1:0]    nbe;
    logic             ncs, nwe, noe;
    logic [AW-1:0]    usr_addr;
    logic             usr_we;
    logic [DW-1:0]    usr_wdata;
    logic [DW-1:0]    usr_rdata;
    logic [NBANK-1:0] doorbell;
    logic [NBANK-1:0] db_clr;
    logic             busy;

    assign sram_data = tb_drive ? tb_wdata : 'z;

    sram_bus_bank #(.DW(DW), .AW(AW), .NBANK(NBANK), .SYNC(SYNC)) dut (
        .clk(clk), .reset(reset), .sram_data(sram_data), .addr(addr), .nbe(nbe),
        .ncs(ncs), .nwe(nwe), .noe(noe), .usr_addr(usr_addr), .usr_we(usr_we),
        .usr_wdata(usr_wdata), .usr_rdata(usr_rdata), .doorbell(doorbell),
        .db_clr(db_clr), .busy(busy)
    );

    typedef struct {
        bit               wr;
        logic [AW-1:0]    a;
        logic [DW-1:0]    d;
        logic [NB-1:0]    be;
        logic [DW-1:0]    exp;
        logic [NBANK-1:0] exp_db;
    } vec_t;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [DW-1:0]    model_mem [DEPTH];
    bit               written   [DEPTH];
    logic [NBANK-1:0] model_db;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++) if (!be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    task automatic model_cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                   input logic [NB-1:0] be, input logic [NBANK-1:0] clr);
        logic [AW-BW-1:0] low;
        model_db = model_db & ~clr;
        model_mem[a] = merge(model_mem[a], d, be);
        written[a] = 1'b1;
        low = a[AW-BW-1:0];
        if (&low) model_db[a[AW-1 -: BW]] = 1'b1;
    endtask

    // CPU write: strobes low for SYNC+1 clocks; optional db_clr / user write on the commit clock.
    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be,
                             input logic [NBANK-1:0] clr, input bit collide, input logic [DW-1:0] udata);
        @(posedge clk); #1;
        addr = a; tb_wdata = d; nbe = be; tb_drive = 1'b1; ncs = 1'b0; nwe = 1'b0;
        repeat (SYNC + 1) @(posedge clk);
        #1; nwe = 1'b1; ncs = 1'b1;
        repeat (SYNC) @(posedge clk);
        #1; db_clr = clr;
        if (collide) begin
            usr_addr = a; usr_wdata = udata; usr_we = 1'b1;
        end
        @(posedge clk); #1;
        db_clr = '0; usr_we = 1'b0; tb_drive = 1'b0; nbe = '1;
        model_cpu_write(a, d, be, clr);
        checkOutput("busy_after_write", 64'(busy), 64'(0));
        if (collide) checkOutput("collide_usr_rdata", 64'(usr_rdata), 64'(model_mem[a]));
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat,
                            output logic [DW-1:0] rel, output logic bsy);
        @(posedge clk); #1;
        addr = a; ncs = 1'b0; noe = 1'b0; lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (sram_data !== PULL) break;
        end
        d = sram_data; bsy = busy;
        noe = 1'b1; ncs = 1'b1;
        #1 rel = sram_data;
        repeat (SYNC + 2) @(posedge clk);
        #1;
    endtask

    task automatic check_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        logic [DW-1:0] d, rel;
        int lat;
        logic bsy;
        cpu_read(a, d, lat, rel, bsy);
        checkOutput({tag, "_data"}, 64'(d), 64'(exp));
        checkOutput({tag, "_latency"}, 64'(lat), 64'(SYNC + 2));
        checkOutput({tag, "_release"}, 64'(rel), 64'(PULL));
        checkOutput({tag, "_busy_during"}, 64'(bsy), 64'(1));
        checkOutput({tag, "_busy_after"}, 64'(busy), 64'(0));
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.wr) begin
            cpu_write(v.a, v.d, v.be, '0, 1'b0, '0);
            checkOutput("vec_doorbell", 64'(doorbell), 64'(v.exp_db));
        end else begin
            check_read("vec_read", v.a, v.exp);
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NB-1:0] be;
        logic [AW-BW-1:0] ones_low;

        reset = 1'b0; ncs = 1'b1; nwe = 1'b1; noe = 1'b1; nbe = '1; addr = '0;
        tb_drive = 1'b0; tb_wdata = '0; usr_addr = '0; usr_we = 1'b0; usr_wdata = '0;
        db_clr = '0; model_db = '0;
        for (int i = 0; i < DEPTH; i++) begin
            written[i] = 1'b0;
            model_mem[i] = '0;
        end

        #1;
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_doorbell", 64'(doorbell), 64'(0));
        checkOutput("reset_usr_rdata", 64'(usr_rdata), 64'(0));
        checkOutput("reset_bus_release", 64'(sram_data), 64'(PULL));
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 10; i++) vecs.push_back('{1'b1, AW'(i), DW'(i), '0, '0, '0});
        for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, AW'(i), '0, '1, DW'(i), '0});
        vecs.push_back('{1'b1, AW'(5), 16'hA5A5, 2'b00, '0, 2'b00});
        vecs.push_back('{1'b1, AW'(5), 16'h1234, 2'b10, '0, 2'b00});
        vecs.push_back('{1'b0, AW'(5), '0, '1, 16'hA534, '0});
        vecs.push_back('{1'b1, 10'h1FF, 16'hBEEF, 2'b00, '0, 2'b01});
        vecs.push_back('{1'b1, 10'h3FF, 16'h0042, 2'b00, '0, 2'b11});
        vecs.push_back('{1'b0, 10'h1FF, '0, '1, 16'hBEEF, '0});
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // db_clr clears only the selected bank
        @(posedge clk); #1 db_clr = 2'b01;
        @(posedge clk); #1 db_clr = 2'b00;
        model_db = model_db & ~2'b01;
        checkOutput("db_clr_bank0", 64'(doorbell), 64'(2'b10));

        // doorbell set wins over a same-clock clear
        cpu_write(10'h1FF, 16'h0777, 2'b00, 2'b01, 1'b0, '0);
        checkOutput("db_set_wins", 64'(doorbell), 64'(2'b11));

        // user write collides with CPU commit to addr 7
        cpu_write(AW'(7), 16'h2222, 2'b00, '0, 1'b1, 16'h1111);
        usr_addr = AW'(7);
        @(posedge clk); #1;
        checkOutput("collide_ram7_usr", 64'(usr_rdata), 64'(16'h2222));
        check_read("collide_ram7_cpu", AW'(7), 16'h2222);

        // reset during READ_DRIVE releases the bus at once
        @(posedge clk); #1; addr = AW'(9); ncs = 1'b0; noe = 1'b0;
        repeat (SYNC + 2) @(posedge clk);
        #1 checkOutput("abort_driving", 64'(sram_data), 64'(16'h0009));
        reset = 1'b0;
        #1;
        checkOutput("abort_release", 64'(sram_data), 64'(PULL));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_doorbell", 64'(doorbell), 64'(0));
        model_db = '0;
        ncs = 1'b1; noe = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        cpu_write(AW'(3), 16'h0333, 2'b00, '0, 1'b0, '0);
        check_read("abort_then_rw3", AW'(3), 16'h0333);

        // reset during WRITE commits nothing
        @(posedge clk); #1;
        addr = AW'(4); tb_wdata = 16'hDEAD; nbe = '0; tb_drive = 1'b1; ncs = 1'b0; nwe = 1'b0;
        repeat (SYNC + 2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("wr_abort_busy", 64'(busy), 64'(0));
        ncs = 1'b1; nwe = 1'b1; tb_drive = 1'b0; nbe = '1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check_read("wr_abort_no_commit", AW'(4), 16'h0004);

        // randomized traffic against the reference model
        for (int it = 0; it < 150; it++) begin
            int op;
            op = $urandom_range(0, 4);
            a = AW'($urandom);
            if (op == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    ones_low = '1;
                    a[AW-BW-1:0] = ones_low;
                end
                be = written[a] ? NB'($urandom) : '0;
                d = DW'($urandom);
                if (merge(model_mem[a], d, be) == PULL) d[0] = ~d[0];
                if (merge(model_mem[a], d, be) == PULL) be = '0;
                cpu_write(a, d, be, '0, 1'b0, '0);
                checkOutput("rand_doorbell", 64'(doorbell), 64'(model_db));
            end else if (op == 1 || op == 3) begin
                for (int t = 0; t < 50 && !written[a]; t++) a = AW'($urandom);
                if (!written[a]) a = AW'(0);
                if (op == 1) begin
                    check_read("rand_cpu_read", a, model_mem[a]);
                end else begin
                    @(posedge clk); #1 usr_addr = a;
                    @(posedge clk); #1;
                    checkOutput("rand_usr_read", 64'(usr_rdata), 64'(model_mem[a]));
                end
            end else if (op == 2) begin
                d = DW'($urandom);
                if (d == PULL) d = '0;
                @(posedge clk); #1 usr_addr = a; usr_wdata = d; usr_we = 1'b1;
                @(posedge clk); #1 usr_we = 1'b0;
                model_mem[a] = d;
                written[a] = 1'b1;
            end else begin
                logic [NBANK-1:0] m;
                m = NBANK'($urandom);
                @(posedge clk); #1 db_clr = m;
                @(posedge clk); #1 db_clr = '0;
                model_db = model_db & ~m;
                checkOutput("rand_db_clr", 64'(doorbell), 64'(model_db));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
